// File: rtl/aibnd_dll_code_ctrl.sv
// DLL loop controller: filters phase-detector early/late samples into a 10-bit
// delay code, sequences code_valid around each code change and flags lock.
// Optional override port pair is compiled in with AIBND_DLL_CODE_OVRD_EN.
module aibnd_dll_code_ctrl #(
  parameter int         FILT_TH   = 4,
  parameter int         SETTLE    = 2,
  parameter int         LOCK_REV  = 4,
  parameter logic [9:0] INIT_CODE = 10'd0
) (
  input  logic       ck,
  input  logic       nrst,
  input  logic       dll_en,
  input  logic       pd_valid,
  input  logic       pd_up,
`ifdef AIBND_DLL_CODE_OVRD_EN
  input  logic       ovrd_en,
  input  logic [9:0] ovrd_code,
`endif
  input  logic       vcc_aibnd,
  input  logic       vss_aibnd,
  output logic [6:0] f_gray,
  output logic [2:0] i_gray,
  output logic       code_valid,
  output logic       dll_lock,
  output logic [9:0] code_bin,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DROP  = 2'd2,
    ST_RAISE = 2'd3
  } state_t;

  localparam logic [3:0]        SETTLE_M1  = 4'(SETTLE - 1);
  localparam logic [3:0]        LOCK_REV_L = 4'(LOCK_REV);
  localparam logic signed [4:0] TH_P       = 5'(FILT_TH);
  localparam logic signed [4:0] TH_N       = 5'(-FILT_TH);
  localparam logic [6:0]        INIT_F     = INIT_CODE[9:3] ^ (INIT_CODE[9:3] >> 1);
  localparam logic [2:0]        INIT_I     = INIT_CODE[2:0] ^ (INIT_CODE[2:0] >> 1);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic signed [4:0] r_acc;
  logic [3:0]        r_rev;
  logic              r_last_vld;
  logic              r_last_dir;
  logic              r_step_dir;
  logic              r_ovrd_step;
  logic [9:0]        r_tgt;
  logic [9:0]        r_code;
  logic [6:0]        r_f_gray;
  logic [2:0]        r_i_gray;
  logic              r_valid;
  logic              r_lock;

  logic              w_ovrd_en;
  logic [9:0]        w_ovrd_code;
  logic signed [4:0] w_acc_nxt;
  logic              w_hit;
  logic              w_sat;
  logic              w_rev;
  logic [3:0]        w_rev_nxt;
  logic [9:0]        w_code_nxt;
  logic              w_unused;

`ifdef AIBND_DLL_CODE_OVRD_EN
  assign w_ovrd_en   = ovrd_en;
  assign w_ovrd_code = ovrd_code;
`else
  assign w_ovrd_en   = 1'b0;
  assign w_ovrd_code = 10'd0;
`endif

  // Supplies carry no logic function.
  assign w_unused = ^{vcc_aibnd, vss_aibnd};

  assign w_acc_nxt  = pd_up ? (r_acc + 5'sd1) : (r_acc - 5'sd1);
  assign w_hit      = (w_acc_nxt == TH_P) || (w_acc_nxt == TH_N);
  assign w_sat      = pd_up ? (r_code == 10'h3FF) : (r_code == 10'h000);
  assign w_rev      = r_last_vld && (r_last_dir != pd_up);
  assign w_rev_nxt  = (r_rev == 4'hF) ? 4'hF : (r_rev + 4'd1);
  assign w_code_nxt = r_ovrd_step ? r_tgt :
                      (r_step_dir ? (r_code + 10'd1) : (r_code - 10'd1));

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      r_state     <= ST_INIT;
      r_cnt       <= 4'd0;
      r_acc       <= 5'sd0;
      r_rev       <= 4'd0;
      r_last_vld  <= 1'b0;
      r_last_dir  <= 1'b0;
      r_step_dir  <= 1'b0;
      r_ovrd_step <= 1'b0;
      r_tgt       <= INIT_CODE;
      r_code      <= INIT_CODE;
      r_f_gray    <= INIT_F;
      r_i_gray    <= INIT_I;
      r_valid     <= 1'b0;
      r_lock      <= 1'b0;
    end else begin
      if (w_ovrd_en) r_lock <= 1'b0;
      case (r_state)
        ST_INIT: begin
          r_acc <= 5'sd0;
          if (r_cnt == SETTLE_M1) begin
            r_cnt   <= 4'd0;
            r_valid <= 1'b1;
            r_state <= ST_TRACK;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_TRACK: begin
          if (w_ovrd_en) begin
            r_acc <= 5'sd0;
            if (w_ovrd_code != r_code) begin
              r_tgt       <= w_ovrd_code;
              r_ovrd_step <= 1'b1;
              r_valid     <= 1'b0;
              r_cnt       <= 4'd0;
              r_state     <= ST_DROP;
            end
          end else if (!dll_en) begin
            r_acc      <= 5'sd0;
            r_rev      <= 4'd0;
            r_last_vld <= 1'b0;
            r_last_dir <= 1'b0;
            r_lock     <= 1'b0;
            r_valid    <= 1'b1;
          end else if (pd_valid) begin
            if (w_hit) begin
              r_acc      <= 5'sd0;
              r_step_dir <= pd_up;
              // A saturated step is dropped entirely: it is not a real step
              // and so does not become the reference for reversal detection.
              if (!w_sat) begin
                r_ovrd_step <= 1'b0;
                r_valid     <= 1'b0;
                r_cnt       <= 4'd0;
                r_state     <= ST_DROP;
                r_last_vld  <= 1'b1;
                r_last_dir  <= pd_up;
                if (w_rev) begin
                  r_rev <= w_rev_nxt;
                  if (w_rev_nxt >= LOCK_REV_L) r_lock <= 1'b1;
                end
              end
            end else begin
              r_acc <= w_acc_nxt;
            end
          end
        end
        ST_DROP: begin
          if (r_cnt == SETTLE_M1) begin
            r_cnt    <= 4'd0;
            r_code   <= w_code_nxt;
            r_f_gray <= w_code_nxt[9:3] ^ (w_code_nxt[9:3] >> 1);
            r_i_gray <= w_code_nxt[2:0] ^ (w_code_nxt[2:0] >> 1);
            r_state  <= ST_RAISE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_RAISE: begin
          if (r_cnt == SETTLE_M1) begin
            r_cnt   <= 4'd0;
            r_valid <= 1'b1;
            r_state <= ST_TRACK;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign f_gray     = r_f_gray;
  assign i_gray     = r_i_gray;
  assign code_valid = r_valid;
  assign dll_lock   = r_lock;
  assign code_bin   = r_code;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_aibnd_dll_code_ctrl.sv
// Self-checking bench for aibnd_dll_code_ctrl: directed scenarios plus random
// phase-detector traffic against an edge-timeline reference model.
module tb_aibnd_dll_code_ctrl;

  localparam int FILT_TH   = 4;
  localparam int SETTLE    = 2;
  localparam int LOCK_REV  = 4;
  localparam int INIT_CODE = 0;

  // clock / reset
  logic ck = 1'b0;
  logic nrst = 1'b0;
  always #5 ck = ~ck;

  logic       dll_en = 1'b0;
  logic       pd_valid = 1'b0;
  logic       pd_up = 1'b0;
  logic       t_ovrd = 1'b0;
  logic [9:0] t_ovrd_code = 10'd0;
  logic [6:0] f_gray;
  logic [2:0] i_gray;
  logic       code_valid;
  logic       dll_lock;
  logic [9:0] code_bin;
  logic [1:0] dbg_state;

  aibnd_dll_code_ctrl #(
    .FILT_TH(FILT_TH), .SETTLE(SETTLE), .LOCK_REV(LOCK_REV), .INIT_CODE(10'(INIT_CODE))
  ) dut (
    .ck(ck), .nrst(nrst), .dll_en(dll_en), .pd_valid(pd_valid), .pd_up(pd_up),
`ifdef AIBND_DLL_CODE_OVRD_EN
    .ovrd_en(t_ovrd), .ovrd_code(t_ovrd_code),
`endif
    .vcc_aibnd(1'b1), .vss_aibnd(1'b0),
    .f_gray(f_gray), .i_gray(i_gray), .code_valid(code_valid),
    .dll_lock(dll_lock), .code_bin(code_bin), .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks the timeline of edges since reset release and
  // schedules code change / valid rise as absolute edge numbers.
  int m_e, m_code, m_new_code, m_net, m_rev, m_prev;
  int m_valid_at, m_change_at, m_track_from;
  bit m_valid, m_lock;

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_e = 0; m_code = INIT_CODE; m_new_code = INIT_CODE;
    m_net = 0; m_rev = 0; m_prev = 0;
    m_valid = 0; m_lock = 0;
    m_valid_at = SETTLE; m_change_at = -1; m_track_from = SETTLE + 1;
  endtask

  task automatic launch(input int c);
    m_valid = 0;
    m_new_code = c;
    m_change_at = m_e + SETTLE;
    m_valid_at = m_e + 2 * SETTLE;
    m_track_from = m_e + 2 * SETTLE + 1;
  endtask

  task automatic model_edge(input bit en, input bit v, input bit up);
    int dir;
    bit tracking;
    m_e++;
    tracking = (m_e >= m_track_from);
    if (t_ovrd) m_lock = 0;
    if (m_e == m_change_at) m_code = m_new_code;
    if (m_e == m_valid_at) m_valid = 1;
    if (tracking) begin
      if (t_ovrd) begin
        m_net = 0;
        if (int'(t_ovrd_code) != m_code) launch(int'(t_ovrd_code));
      end else if (!en) begin
        m_net = 0; m_rev = 0; m_prev = 0; m_lock = 0;
      end else if (v) begin
        m_net += up ? 1 : -1;
        if (m_net == FILT_TH || m_net == -FILT_TH) begin
          dir = (m_net > 0) ? 1 : -1;
          m_net = 0;
          if (m_code + dir >= 0 && m_code + dir <= 1023) begin
            launch(m_code + dir);
            if (m_prev != 0 && m_prev != dir) begin
              m_rev = (m_rev < 15) ? m_rev + 1 : 15;
              if (m_rev >= LOCK_REV) m_lock = 1;
            end
            m_prev = dir;
          end
        end
      end
    end
  endtask

  task automatic compare_all(input string where);
    check({where, ".code_bin"}, 32'(code_bin), 32'(m_code));
    check({where, ".f_gray"}, 32'(f_gray), 32'(gray(m_code >> 3)));
    check({where, ".i_gray"}, 32'(i_gray), 32'(gray(m_code & 7)));
    check({where, ".code_valid"}, 32'(code_valid), 32'(m_valid));
    check({where, ".dll_lock"}, 32'(dll_lock), 32'(m_lock));
  endtask

  // driver tasks
  task automatic cyc(input bit en, input bit v, input bit up);
    dll_en = en; pd_valid = v; pd_up = up;
    @(posedge ck);
    model_edge(en, v, up);
    #1;
    compare_all("cyc");
  endtask

  task automatic samples(input int n, input bit up);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, up);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic quiesce();
    for (int i = 0; i < 2 * SETTLE + 2; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // reset state
    model_reset();
    #12;
    compare_all("reset");
    check("reset.code_valid", 32'(code_valid), 32'd0);
    nrst = 1'b1;
    model_reset();
    cyc(1'b1, 1'b0, 1'b0);
    check("init.valid_e1", 32'(code_valid), 32'd0);
    cyc(1'b1, 1'b0, 1'b0);
    check("init.valid_e2", 32'(code_valid), 32'd1);
    check("init.gray", 32'({f_gray, i_gray}), 32'd0);

    // down saturation at code 0
    samples(4, 1'b0);
    check("sat0.code", 32'(code_bin), 32'd0);
    check("sat0.valid", 32'(code_valid), 32'd1);
    idle(3);

    // walk up to 12, then the 12 -> 13 step with exact timing
    for (int k = 0; k < 12; k++) begin samples(4, 1'b1); idle(2 * SETTLE); end
    check("walk12.code", 32'(code_bin), 32'd12);
    samples(4, 1'b1);
    check("step13.valid_low", 32'(code_valid), 32'd0);
    check("step13.code_hold", 32'(code_bin), 32'd12);
    idle(SETTLE);
    check("step13.code", 32'(code_bin), 32'd13);
    check("step13.f_gray", 32'(f_gray), 32'd1);
    check("step13.i_gray", 32'(i_gray), 32'd7);
    check("step13.valid_still_low", 32'(code_valid), 32'd0);
    idle(SETTLE);
    check("step13.valid_high", 32'(code_valid), 32'd1);

    // net-count filter: up, down, up, up, up, up
    cyc(1, 1, 1); cyc(1, 1, 0); cyc(1, 1, 1); cyc(1, 1, 1); cyc(1, 1, 1);
    check("filter.no_step_yet", 32'(code_valid), 32'd1);
    cyc(1, 1, 1);
    check("filter.step", 32'(code_valid), 32'd0);
    idle(2 * SETTLE);
    check("filter.code", 32'(code_bin), 32'd14);

    // alternate directions to build reversals
    for (int k = 0; k < 4; k++) begin
      check("lock.before", 32'(dll_lock), 32'd0);
      samples(4, (k % 2) == 1);
      idle(2 * SETTLE);
    end
    check("lock.after4", 32'(dll_lock), 32'd1);
    check("lock.code", 32'(code_bin), 32'd14);

    // dll_en dropped mid-DROP: sequence completes, then lock clears, code frozen
    samples(4, 1'b0);
    cyc(0, 1, 1);
    for (int i = 0; i < 2 * SETTLE - 1; i++) cyc(0, 0, 0);
    check("en_off.code", 32'(code_bin), 32'd13);
    check("en_off.valid", 32'(code_valid), 32'd1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'(i % 2));
    check("en_off.lock", 32'(dll_lock), 32'd0);
    check("en_off.frozen", 32'(code_bin), 32'd13);

    // random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);

    // walk to the top and test upper saturation
    quiesce();
    while (m_code < 1023) begin samples(4, 1'b1); idle(2 * SETTLE); end
    check("top.code", 32'(code_bin), 32'd1023);
    samples(4, 1'b1);
    check("sat1023.code", 32'(code_bin), 32'd1023);
    check("sat1023.valid", 32'(code_valid), 32'd1);
    idle(2 * SETTLE);

    // reset asserted mid-RAISE
    samples(4, 1'b0);
    idle(SETTLE + 1);
    check("raise.code", 32'(code_bin), 32'd1022);
    #2 nrst = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    check("async_rst.valid", 32'(code_valid), 32'd0);
    check("async_rst.code", 32'(code_bin), 32'(INIT_CODE));
    #1 nrst = 1'b1;
    idle(SETTLE + 1);

`ifdef AIBND_DLL_CODE_OVRD_EN
    t_ovrd_code = 10'd517;
    t_ovrd = 1'b1;
    samples(4, 1'b1);
    idle(2 * SETTLE);
    check("ovrd.code", 32'(code_bin), 32'd517);
    check("ovrd.lock", 32'(dll_lock), 32'd0);
    check("ovrd.valid", 32'(code_valid), 32'd1);
    t_ovrd = 1'b0;
    idle(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #5_000_000;
    $display("FAIL timeout reached got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
